// File: rtl/prefix_scan_ctrl_pkg.sv
// Shared decode definitions for the legacy-prefix scanner: prefix byte values,
// segment override codes, FSM state encoding and the per-byte class record.
package prefix_scan_ctrl_pkg;

   localparam int MAX_PREFIX_DEF = 4;
   localparam int CNT_W_DEF      = 3;

   localparam logic [7:0] PFX_ES     = 8'h26;
   localparam logic [7:0] PFX_CS     = 8'h2E;
   localparam logic [7:0] PFX_SS     = 8'h36;
   localparam logic [7:0] PFX_DS     = 8'h3E;
   localparam logic [7:0] PFX_FS     = 8'h64;
   localparam logic [7:0] PFX_GS     = 8'h65;
   localparam logic [7:0] PFX_OPSIZE = 8'h66;
   localparam logic [7:0] PFX_LOCK   = 8'hF0;
   localparam logic [7:0] PFX_REPNE  = 8'hF2;
   localparam logic [7:0] PFX_REP    = 8'hF3;

   localparam logic [2:0] SEG_ES = 3'd0;
   localparam logic [2:0] SEG_CS = 3'd1;
   localparam logic [2:0] SEG_SS = 3'd2;
   localparam logic [2:0] SEG_DS = 3'd3;
   localparam logic [2:0] SEG_FS = 3'd4;
   localparam logic [2:0] SEG_GS = 3'd5;

   typedef enum logic {
      ST_SCAN = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   typedef struct packed {
      logic       is_pfx;
      logic       is_seg;
      logic       is_opsize;
      logic       is_lock;
      logic       is_rep;
      logic       is_repne;
      logic [2:0] seg;
   } pfx_class_t;

endpackage

// File: rtl/prefix_scan_ctrl_if.sv
// Fetch-window and prefix-bundle signals between fetch, the prefix scanner and opcode decode.
interface prefix_scan_ctrl_if #(
   parameter int CNT_W = 3
);
   // Window: a byte group moves when win_valid & win_ready are both high on a clk edge;
   // bundle: it is taken when pfx_valid & pfx_ready are both high, and holds stable until then.
   logic             win_valid;
   logic [23:0]      win_bytes;
   logic             win_ready;
   logic [1:0]       shift_amt;
   logic             pfx_valid;
   logic             pfx_ready;
   logic [CNT_W-1:0] pfx_count;
   logic             opsize_ovr;
   logic             seg_ovr_vld;
   logic [2:0]       seg_ovr;
   logic             lock;
   logic             rep;
   logic             repne;
   logic             pfx_fault;

   modport master (
      output win_valid, win_bytes, pfx_ready,
      input  win_ready, shift_amt, pfx_valid, pfx_count, opsize_ovr,
             seg_ovr_vld, seg_ovr, lock, rep, repne, pfx_fault
   );

   modport slave (
      input  win_valid, win_bytes, pfx_ready,
      output win_ready, shift_amt, pfx_valid, pfx_count, opsize_ovr,
             seg_ovr_vld, seg_ovr, lock, rep, repne, pfx_fault
   );
endinterface

// File: rtl/prefix_scan_ctrl_pfx_byte_class.sv
// Combinational classifier for one fetch byte: prefix flag, prefix kind and segment code.
module prefix_scan_ctrl_pfx_byte_class
   import prefix_scan_ctrl_pkg::*;
(
   input  logic [7:0] i_byte,
   output pfx_class_t o_cls
);

   always_comb begin
      o_cls = '0;
      case (i_byte)
         PFX_ES:     begin o_cls.is_seg = 1'b1; o_cls.seg = SEG_ES; end
         PFX_CS:     begin o_cls.is_seg = 1'b1; o_cls.seg = SEG_CS; end
         PFX_SS:     begin o_cls.is_seg = 1'b1; o_cls.seg = SEG_SS; end
         PFX_DS:     begin o_cls.is_seg = 1'b1; o_cls.seg = SEG_DS; end
         PFX_FS:     begin o_cls.is_seg = 1'b1; o_cls.seg = SEG_FS; end
         PFX_GS:     begin o_cls.is_seg = 1'b1; o_cls.seg = SEG_GS; end
         PFX_OPSIZE: o_cls.is_opsize = 1'b1;
         PFX_LOCK:   o_cls.is_lock   = 1'b1;
         PFX_REPNE:  o_cls.is_repne  = 1'b1;
         PFX_REP:    o_cls.is_rep    = 1'b1;
         default:    o_cls = '0;
      endcase
      o_cls.is_pfx = o_cls.is_seg | o_cls.is_opsize | o_cls.is_lock |
                     o_cls.is_rep | o_cls.is_repne;
   end

endmodule

// File: rtl/prefix_scan_ctrl.sv
// Legacy-prefix scanner: consumes leading prefix bytes from 3-byte fetch windows,
// accumulates them per instruction and hands one bundle to opcode decode.
module prefix_scan_ctrl
   import prefix_scan_ctrl_pkg::*;
#(
   parameter int MAX_PREFIX = MAX_PREFIX_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   prefix_scan_ctrl_if.slave    bus,
   output state_e               dbg_state
);

   localparam logic [CNT_W:0] MAX_W = MAX_PREFIX[CNT_W:0];
   localparam logic [CNT_W:0] SAT_W = {1'b0, {CNT_W{1'b1}}};

   pfx_class_t       w_cls [3];
   logic [2:0]       w_take;
   logic [1:0]       w_n;
   logic [CNT_W:0]   w_sum;
   logic             w_win_ready;
   logic             w_clr;

   state_e           r_state, w_nxt_state;
   logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
   logic             r_opsize, w_nxt_opsize;
   logic             r_seg_vld, w_nxt_seg_vld;
   logic [2:0]       r_seg, w_nxt_seg;
   logic             r_lock, w_nxt_lock;
   logic             r_rep, w_nxt_rep;
   logic             r_repne, w_nxt_repne;
   logic             r_fault, w_nxt_fault;

   // Byte 0 is the oldest (win_bytes[23:16]).
   for (genvar g = 0; g < 3; g++) begin : g_cls
      prefix_scan_ctrl_pfx_byte_class u_cls (
         .i_byte (bus.win_bytes[23-8*g -: 8]),
         .o_cls  (w_cls[g])
      );
   end

   assign w_take[0] = w_cls[0].is_pfx;
   assign w_take[1] = w_take[0] & w_cls[1].is_pfx;
   assign w_take[2] = w_take[1] & w_cls[2].is_pfx;
   assign w_n       = {1'b0, w_take[0]} + {1'b0, w_take[1]} + {1'b0, w_take[2]};
   assign w_sum     = {1'b0, r_cnt} + {{(CNT_W-1){1'b0}}, w_n};

   assign w_win_ready = reset & ~flush & (r_state == ST_SCAN);
   assign w_clr       = flush | ((r_state == ST_HOLD) & bus.pfx_ready);

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_cnt     = r_cnt;
      w_nxt_opsize  = r_opsize;
      w_nxt_seg_vld = r_seg_vld;
      w_nxt_seg     = r_seg;
      w_nxt_lock    = r_lock;
      w_nxt_rep     = r_rep;
      w_nxt_repne   = r_repne;
      w_nxt_fault   = r_fault;
      if (r_state == ST_SCAN && bus.win_valid) begin
         // Merge oldest to youngest so the later segment / rep prefix wins.
         for (int i = 0; i < 3; i++) begin
            if (w_take[i]) begin
               if (w_cls[i].is_opsize) w_nxt_opsize = 1'b1;
               if (w_cls[i].is_lock)   w_nxt_lock   = 1'b1;
               if (w_cls[i].is_seg) begin
                  w_nxt_seg_vld = 1'b1;
                  w_nxt_seg     = w_cls[i].seg;
               end
               if (w_cls[i].is_rep) begin
                  w_nxt_rep   = 1'b1;
                  w_nxt_repne = 1'b0;
               end
               if (w_cls[i].is_repne) begin
                  w_nxt_repne = 1'b1;
                  w_nxt_rep   = 1'b0;
               end
            end
         end
         w_nxt_cnt = (w_sum > SAT_W) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
         if (w_sum > MAX_W) begin
            w_nxt_fault = 1'b1;
            w_nxt_state = ST_HOLD;
         end else if (w_n != 2'd3) begin
            w_nxt_state = ST_HOLD;
         end
      end
      // Flush and the bundle handshake both retire the instruction; flush wins over any accept.
      if (w_clr) begin
         w_nxt_state   = ST_SCAN;
         w_nxt_cnt     = '0;
         w_nxt_opsize  = 1'b0;
         w_nxt_seg_vld = 1'b0;
         w_nxt_seg     = 3'd0;
         w_nxt_lock    = 1'b0;
         w_nxt_rep     = 1'b0;
         w_nxt_repne   = 1'b0;
         w_nxt_fault   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_SCAN;
         r_cnt     <= '0;
         r_opsize  <= 1'b0;
         r_seg_vld <= 1'b0;
         r_seg     <= 3'd0;
         r_lock    <= 1'b0;
         r_rep     <= 1'b0;
         r_repne   <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_cnt     <= w_nxt_cnt;
         r_opsize  <= w_nxt_opsize;
         r_seg_vld <= w_nxt_seg_vld;
         r_seg     <= w_nxt_seg;
         r_lock    <= w_nxt_lock;
         r_rep     <= w_nxt_rep;
         r_repne   <= w_nxt_repne;
         r_fault   <= w_nxt_fault;
      end
   end

   assign bus.win_ready   = w_win_ready;
   assign bus.shift_amt   = w_win_ready ? w_n : 2'd0;
   assign bus.pfx_valid   = (r_state == ST_HOLD) & ~flush;
   assign bus.pfx_count   = r_cnt;
   assign bus.opsize_ovr  = r_opsize;
   assign bus.seg_ovr_vld = r_seg_vld;
   assign bus.seg_ovr     = r_seg;
   assign bus.lock        = r_lock;
   assign bus.rep         = r_rep;
   assign bus.repne       = r_repne;
   assign bus.pfx_fault   = r_fault;
   assign dbg_state       = r_state;

endmodule

// File: tb/tb_prefix_scan_ctrl.sv
// Bench for prefix_scan_ctrl: directed scenarios plus random windows against a byte-list model.
module tb_prefix_scan_ctrl;
   import prefix_scan_ctrl_pkg::*;

   localparam int MAXP = 4;
   localparam int CW   = 3;

   logic   clk = 1'b0;
   logic   reset;
   logic   flush;
   state_e dbg_state;

   prefix_scan_ctrl_if #(.CNT_W(CW)) bus ();

   prefix_scan_ctrl #(.MAX_PREFIX(MAXP), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [11:0] exp_q[$];
   logic [7:0]  pfx_q[$];
   logic [7:0]  pfx_tab [10] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64,
                                 8'h65, 8'h66, 8'hF0, 8'hF2, 8'hF3};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_prefix(input logic [7:0] b);
      foreach (pfx_tab[i]) if (pfx_tab[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [2:0] seg_code(input logic [7:0] b);
      case (b)
         8'h26:   return 3'd0;
         8'h2E:   return 3'd1;
         8'h36:   return 3'd2;
         8'h3E:   return 3'd3;
         8'h64:   return 3'd4;
         default: return 3'd5;
      endcase
   endfunction

   // Bundle layout: {fault, count[2:0], opsize, seg_vld, seg[2:0], lock, rep, repne}
   function automatic logic [11:0] model_bundle();
      int         total = pfx_q.size();
      logic       opsize = 0, lock = 0, seg_vld = 0, rep = 0, repne = 0;
      logic [2:0] seg = 0;
      logic [2:0] cnt;
      foreach (pfx_q[i]) begin
         logic [7:0] b = pfx_q[i];
         if (b == 8'h66) opsize = 1;
         if (b == 8'hF0) lock = 1;
         if (b == 8'hF3) begin rep = 1; repne = 0; end
         if (b == 8'hF2) begin repne = 1; rep = 0; end
         if (b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65}) begin
            seg_vld = 1;
            seg     = seg_code(b);
         end
      end
      cnt = (total > 7) ? 3'd7 : 3'(total);
      return {(total > MAXP), cnt, opsize, seg_vld, seg, lock, rep, repne};
   endfunction

   function automatic logic [11:0] dut_bundle();
      return {bus.pfx_fault, bus.pfx_count, bus.opsize_ovr, bus.seg_ovr_vld,
              bus.seg_ovr, bus.lock, bus.rep, bus.repne};
   endfunction

   task automatic send_window(input logic [23:0] w, output bit done);
      logic [7:0] b [3];
      int         n = 0;
      b[0] = w[23:16];
      b[1] = w[15:8];
      b[2] = w[7:0];
      for (int i = 0; i < 3; i++) if (n == i && is_prefix(b[i])) n++;
      @(negedge clk);
      bus.win_valid = 1'b1;
      bus.win_bytes = w;
      #1;
      check_eq("win_ready_scan", bus.win_ready, 1);
      check_eq("shift_amt", bus.shift_amt, n);
      @(posedge clk);
      #1;
      bus.win_valid = 1'b0;
      bus.win_bytes = 24'($urandom);
      for (int i = 0; i < n; i++) pfx_q.push_back(b[i]);
      done = (pfx_q.size() > MAXP) || (n < 3);
      if (done) begin
         exp_q.push_back(model_bundle());
         pfx_q.delete();
      end else begin
         check_eq("stay_scan", dbg_state, ST_SCAN);
      end
   endtask

   task automatic take_bundle(input int hold);
      logic [11:0] exp = exp_q.pop_front();
      @(negedge clk);
      check_eq("bundle_valid", bus.pfx_valid, 1);
      check_eq("hold_win_ready", bus.win_ready, 0);
      check_eq("bundle", dut_bundle(), exp);
      for (int k = 0; k < hold; k++) begin
         bus.win_valid = 1'($urandom_range(0, 1));
         bus.win_bytes = {8'h66, 8'h66, 8'h66};
         @(negedge clk);
         check_eq("stall_valid", bus.pfx_valid, 1);
         check_eq("stall_win_ready", bus.win_ready, 0);
         check_eq("stall_bundle", dut_bundle(), exp);
      end
      bus.win_valid = 1'b0;
      bus.pfx_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.pfx_ready = 1'b0;
      @(negedge clk);
      check_eq("post_hs_valid", bus.pfx_valid, 0);
      check_eq("post_hs_win_ready", bus.win_ready, 1);
      check_eq("post_hs_clear", dut_bundle(), 0);
   endtask

   task automatic flush_hold();
      void'(exp_q.pop_front());
      @(negedge clk);
      flush         = 1'b1;
      bus.pfx_ready = 1'($urandom_range(0, 1));
      #1;
      check_eq("flush_valid", bus.pfx_valid, 0);
      check_eq("flush_win_ready", bus.win_ready, 0);
      @(posedge clk);
      #1;
      flush         = 1'b0;
      bus.pfx_ready = 1'b0;
      @(negedge clk);
      check_eq("flush_state", dbg_state, ST_SCAN);
      check_eq("flush_clear", dut_bundle(), 0);
      check_eq("flush_post_valid", bus.pfx_valid, 0);
   endtask

   function automatic logic [7:0] rand_byte();
      if ($urandom_range(0, 3) == 0) return 8'($urandom);
      return pfx_tab[$urandom_range(0, 9)];
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;
      reset         = 1'b0;
      flush         = 1'b0;
      bus.win_valid = 1'b0;
      bus.win_bytes = 24'h0;
      bus.pfx_ready = 1'b0;
      #1;
      check_eq("rst_win_ready", bus.win_ready, 0);
      check_eq("rst_valid", bus.pfx_valid, 0);
      check_eq("rst_bundle", dut_bundle(), 0);
      check_eq("rst_state", dbg_state, ST_SCAN);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Single opsize prefix
      send_window(24'h66B800, done);
      @(negedge clk);
      check_eq("t1_bundle", dut_bundle(), 12'h180);
      take_bundle(0);

      // No prefix
      send_window(24'h90_1234, done);
      take_bundle(0);

      // Spans two windows
      send_window(24'hF32E66, done);
      send_window(24'h2689C0, done);
      @(negedge clk);
      check_eq("t3_bundle", dut_bundle(), 12'h4C2);
      take_bundle(0);

      // Over-length fault
      send_window(24'hF3F2F0, done);
      send_window(24'h3E6490, done);
      @(negedge clk);
      check_eq("t4_bundle", dut_bundle(), 12'hD65);
      take_bundle(3);

      // Reset mid-accumulation
      send_window(24'hF32E66, done);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_win_ready", bus.win_ready, 0);
      check_eq("mid_rst_shift", bus.shift_amt, 0);
      check_eq("mid_rst_bundle", dut_bundle(), 0);
      check_eq("mid_rst_state", dbg_state, ST_SCAN);
      pfx_q.delete();
      @(negedge clk);
      reset = 1'b1;
      send_window(24'h6690AA, done);
      @(negedge clk);
      check_eq("t6_rst_bundle", dut_bundle(), 12'h180);
      take_bundle(0);

      // Flush in HOLD, then flush against a window accept
      send_window(24'hF0_90_00, done);
      flush_hold();
      @(negedge clk);
      flush         = 1'b1;
      bus.win_valid = 1'b1;
      bus.win_bytes = 24'h666666;
      #1;
      check_eq("flush_accept_ready", bus.win_ready, 0);
      @(posedge clk);
      #1;
      flush         = 1'b0;
      bus.win_valid = 1'b0;
      @(negedge clk);
      check_eq("flush_accept_state", dbg_state, ST_SCAN);
      check_eq("flush_accept_clear", dut_bundle(), 0);
      send_window(24'h6690AA, done);
      @(negedge clk);
      check_eq("t6_flush_bundle", dut_bundle(), 12'h180);
      take_bundle(0);

      // Random instructions
      for (int it = 0; it < 200; it++) begin
         done = 0;
         while (!done) begin
            if ($urandom_range(0, 4) == 0) begin
               @(negedge clk);
               bus.pfx_ready = 1'($urandom_range(0, 1));
               #1;
               check_eq("idle_win_ready", bus.win_ready, 1);
               check_eq("idle_valid", bus.pfx_valid, 0);
               @(posedge clk);
               #1;
               bus.pfx_ready = 1'b0;
               check_eq("idle_state", dbg_state, ST_SCAN);
            end
            send_window({rand_byte(), rand_byte(), rand_byte()}, done);
         end
         if ($urandom_range(0, 9) == 0) flush_hold();
         else take_bundle($urandom_range(0, 3));
      end

      check_eq("exp_q_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
